// File: rtl/audio_sample_fifo.sv
// Elastic buffer for stereo sample words between the link op decoder and the I2S sender.
// Primes before playback, repeats words in 22 kHz mode, and paces the link with request ticks.
module audio_sample_fifo #(
   parameter int DEPTH       = 16,
   parameter int AW          = 4,
   parameter int PRIME_LEVEL = 8
) (
   input  logic          mon_clk,
   input  logic          hw_reset_n,
   input  logic          wr_valid,
   input  logic [31:0]   wr_data,
   input  logic          start,
   input  logic          stop,
   input  logic          mode_22k,
   input  logic          rd_req,
   output logic [31:0]   rd_data,
   output logic          rd_valid,
   output logic          playing,
   output logic          request_mode,
   output logic          request_tick,
   output logic          underrun,
   output logic          overflow,
   output logic [AW:0]   level
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_PLAY  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          phase_q, phase_d;
   logic [31:0]   rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d;
   logic          underrun_q, underrun_d;
   logic          overflow_q, overflow_d;
   logic          tick_q, tick_d;

   logic [31:0]   mem_q [DEPTH];

   logic          active;
   logic          out_state;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic [31:0]   head;

   assign active    = (state_q != ST_IDLE);
   assign out_state = (state_q == ST_PLAY) || (state_q == ST_DRAIN);
   assign full      = (level_q == (AW+1)'(DEPTH));
   assign empty     = (level_q == '0);
   assign head      = mem_q[rd_ptr_q];

   // A start flushes the buffer, so any write arriving with it is discarded.
   assign push = active && wr_valid && !full && !start;
   assign pop  = rd_req && out_state && !empty && (!mode_22k || phase_q);

   always_ff @(posedge mon_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      phase_d    = phase_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_req;
      underrun_d = 1'b0;
      overflow_d = active && wr_valid && full && !start;
      tick_d     = start || (pop && (state_q == ST_PLAY));

      // rd_data_q doubles as the held sample replayed on empty reads.
      if (rd_req) begin
         if (!out_state) begin
            rd_data_d = '0;
         end else if (!empty) begin
            rd_data_d = head;
            if (mode_22k) begin
               phase_d = ~phase_q;
            end
         end else begin
            underrun_d = (state_q == ST_PLAY);
         end
      end
      if (!mode_22k) begin
         phase_d = 1'b0;
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      level_d = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

      unique case (state_q)
         ST_IDLE: ;
         ST_PRIME: begin
            if (stop) begin
               state_d = ST_DRAIN;
            end else if (level_q >= (AW+1)'(PRIME_LEVEL)) begin
               state_d = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (stop) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (empty) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (start) begin
         state_d  = ST_PRIME;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         phase_d  = 1'b0;
      end
   end

   always_ff @(posedge mon_clk or negedge hw_reset_n) begin
      if (!hw_reset_n) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         phase_q    <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         underrun_q <= 1'b0;
         overflow_q <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         phase_q    <= phase_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         underrun_q <= underrun_d;
         overflow_q <= overflow_d;
         tick_q     <= tick_d;
      end
   end

   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;
   assign playing      = (state_q == ST_PLAY) || (state_q == ST_DRAIN);
   assign request_mode = (state_q == ST_PRIME) || (state_q == ST_PLAY);
   assign request_tick = tick_q;
   assign underrun     = underrun_q;
   assign overflow     = overflow_q;
   assign level        = level_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Scoreboard bench for audio_sample_fifo: a queue-based playback model predicts every cycle,
// and an independent negedge monitor pops and compares whatever the DUT presents.
module tb_audio_sample_fifo;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   localparam int S_IDLE  = 0;
   localparam int S_PRIME = 1;
   localparam int S_PLAY  = 2;
   localparam int S_DRAIN = 3;

   logic          mon_clk = 1'b0;
   logic          hw_reset_n;
   logic          wr_valid;
   logic [31:0]   wr_data;
   logic          start;
   logic          stop;
   logic          mode_22k;
   logic          rd_req;
   logic [31:0]   rd_data;
   logic          rd_valid;
   logic          playing;
   logic          request_mode;
   logic          request_tick;
   logic          underrun;
   logic          overflow;
   logic [AW:0]   level;

   audio_sample_fifo #(.DEPTH(DEPTH), .AW(AW), .PRIME_LEVEL(8)) dut (
      .mon_clk      (mon_clk),
      .hw_reset_n   (hw_reset_n),
      .wr_valid     (wr_valid),
      .wr_data      (wr_data),
      .start        (start),
      .stop         (stop),
      .mode_22k     (mode_22k),
      .rd_req       (rd_req),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .playing      (playing),
      .request_mode (request_mode),
      .request_tick (request_tick),
      .underrun     (underrun),
      .overflow     (overflow),
      .level        (level)
   );

   always #5 mon_clk = ~mon_clk;

   typedef struct {
      bit         rv;
      bit         ur;
      bit         ov;
      bit         tick;
      bit         play;
      bit         reqm;
      int         lvl;
   } status_t;

   status_t      exp_status[$];
   logic [31:0]  exp_data[$];

   int           n_checks = 0;
   int           n_fail   = 0;
   int           n_rd     = 0;

   int           m_state;
   logic [31:0]  m_q[$];
   logic [31:0]  m_held;
   bit           m_phase;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares the DUT against the oldest prediction every negedge.
   initial begin
      status_t s;
      forever begin
         @(negedge mon_clk);
         if (exp_status.size() > 0) begin
            s = exp_status.pop_front();
            chk("rd_valid", 32'(rd_valid), 32'(s.rv));
            chk("underrun", 32'(underrun), 32'(s.ur));
            chk("overflow", 32'(overflow), 32'(s.ov));
            chk("request_tick", 32'(request_tick), 32'(s.tick));
            chk("playing", 32'(playing), 32'(s.play));
            chk("request_mode", 32'(request_mode), 32'(s.reqm));
            chk("level", 32'(level), 32'(s.lvl));
            if (rd_valid === 1'b1) begin
               if (exp_data.size() == 0) begin
                  chk("rd_data_unexpected", 32'(rd_valid), 32'd0);
               end else begin
                  n_rd++;
                  chk("rd_data", rd_data, exp_data.pop_front());
               end
            end
         end
      end
   end

   task automatic model_reset();
      m_state = S_IDLE;
      m_q.delete();
      m_held  = '0;
      m_phase = 1'b0;
   endtask

   task automatic do_reset();
      status_t e;
      hw_reset_n = 1'b0;
      wr_valid = 1'b0; wr_data = '0; start = 1'b0; stop = 1'b0; rd_req = 1'b0;
      model_reset();
      exp_data.delete();
      #1;
      e = '{rv: 0, ur: 0, ov: 0, tick: 0, play: 0, reqm: 0, lvl: 0};
      exp_status.push_back(e);
      @(negedge mon_clk);
      #1;
      hw_reset_n = 1'b1;
   endtask

   // Applies one cycle of stimulus and predicts the post-edge outputs from the model.
   task automatic step(input bit wv, input logic [31:0] wd, input bit st, input bit sp, input bit rr);
      status_t     e;
      int          pre;
      bit          do_pop;
      bit          do_push;
      logic [31:0] outw;
      wr_valid = wv; wr_data = wd; start = st; stop = sp; rd_req = rr;
      pre = m_q.size();
      do_pop = 0; do_push = 0;
      e = '{rv: rr, ur: 0, ov: 0, tick: 0, play: 0, reqm: 0, lvl: 0};
      if (rr) begin
         if (m_state == S_IDLE || m_state == S_PRIME) begin
            outw = '0;
         end else if (pre > 0) begin
            outw = m_q[0];
            if (!mode_22k || m_phase) do_pop = 1;
            if (mode_22k) m_phase = !m_phase;
         end else begin
            outw = m_held;
            if (m_state == S_PLAY) e.ur = 1;
         end
         m_held = outw;
         exp_data.push_back(outw);
      end
      if (!mode_22k) m_phase = 0;
      if (wv && m_state != S_IDLE && !st) begin
         if (pre == DEPTH) e.ov = 1;
         else do_push = 1;
      end
      e.tick = st || (do_pop && m_state == S_PLAY);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(wd);
      if (st) begin
         m_q.delete();
         m_phase = 0;
         m_state = S_PRIME;
      end else begin
         case (m_state)
            S_PRIME: if (sp) m_state = S_DRAIN; else if (pre >= 8) m_state = S_PLAY;
            S_PLAY:  if (sp) m_state = S_DRAIN;
            S_DRAIN: if (pre == 0) m_state = S_IDLE;
            default: ;
         endcase
      end
      e.lvl  = m_q.size();
      e.play = (m_state == S_PLAY || m_state == S_DRAIN);
      e.reqm = (m_state == S_PRIME || m_state == S_PLAY);
      @(posedge mon_clk);
      exp_status.push_back(e);
      @(negedge mon_clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] wa;
      logic [31:0] wb;
      mode_22k = 1'b0;
      do_reset();

      // Prime to PLAY, leave five entries, then reset asynchronously mid-play.
      step(0, '0, 1, 0, 0);
      for (int k = 1; k <= 8; k++) step(1, 32'h00110000 + 32'(k), 0, 0, 0);
      idle(1);
      for (int k = 0; k < 3; k++) step(0, '0, 0, 0, 1);
      do_reset();
      step(0, '0, 0, 0, 1);
      idle(1);

      // Eight ordered words, eight reads, eight ticks.
      step(0, '0, 1, 0, 0);
      for (int k = 1; k <= 8; k++) step(1, {16'(k), 16'(k)}, 0, 0, 0);
      idle(1);
      for (int k = 0; k < 8; k++) step(0, '0, 0, 0, 1);

      // 22 kHz repeat: A,A,B,B.
      mode_22k = 1'b1;
      wa = 32'hAAAA_1111;
      wb = 32'hBBBB_2222;
      step(1, wa, 0, 0, 0);
      step(1, wb, 0, 0, 0);
      for (int k = 0; k < 4; k++) step(0, '0, 0, 0, 1);
      mode_22k = 1'b0;

      // Empty read in PLAY: held sample plus underrun.
      step(0, '0, 0, 0, 1);
      step(0, '0, 0, 0, 1);

      // Seventeen writes without reads: full, one overflow.
      step(0, '0, 1, 0, 0);
      for (int k = 0; k < 17; k++) step(1, 32'hC0DE_0000 + 32'(k), 0, 0, 0);
      idle(1);

      // Drain down to three, stop, drain, back to IDLE.
      for (int k = 0; k < 13; k++) step(0, '0, 0, 0, 1);
      step(0, '0, 0, 1, 0);
      for (int k = 0; k < 3; k++) step(0, '0, 0, 0, 1);
      idle(2);
      step(0, '0, 0, 0, 1);

      // start and stop together: start wins.
      step(1, 32'h1234_5678, 1, 1, 0);
      idle(1);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0) mode_22k = ~mode_22k;
         step($urandom_range(0, 99) < 40, $urandom(),
              $urandom_range(0, 149) == 0, $urandom_range(0, 199) == 0,
              $urandom_range(0, 99) < 35);
      end
      idle(3);
      chk("pending_expectations", 32'(exp_status.size() + exp_data.size()), 32'd0);
      chk("reads_seen_nonzero", 32'(n_rd > 20), 32'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
